dsram_like_responder: RTL and testbench

- Responder (slave) end of the data_sram req/addr_ok/data_ok interface driven by the execute stage.
- Accepts load/store requests, performs them on a single-port synchronous word RAM, and returns in-order data_ok responses (with rdata for loads) after a configurable delay.
- Supports up to DEPTH outstanding requests; used as the data-side memory model and as the bridge in front of on-chip data RAM.

---
 rtl/dsram_like_responder.sv | 133 +++++++++++++
 tb/tb_dsram_like_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_like_responder.sv
// Responder end of the data_sram req/addr_ok/data_ok interface: issues each accepted
// request to a single-port synchronous word RAM and answers strictly in order after a fixed delay.
module dsram_like_responder #(
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 4,
  parameter int DATA_DELAY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [31:0]       data_sram_rdata,
  input  logic              addr_stall,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [3:0]       DLY_INIT  = 4'(DATA_DELAY);

  // Response queue: per-slot occupancy, store flag, data-valid flag, delay counter and data.
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_occ;
  logic [DEPTH-1:0] r_is_wr;
  logic [DEPTH-1:0] r_vld;
  logic [3:0]       r_dly  [DEPTH];
  logic [31:0]      r_data [DEPTH];

  // The load issued last cycle whose RAM data is arriving on ram_rdata now.
  logic             r_cap_pend;
  logic [PTR_W-1:0] r_cap_idx;

  logic             w_push;
  logic             w_pop;
  logic             w_head_cap;
  logic [DEPTH-1:0] w_eff_vld;
  logic             w_unused;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // Size and the byte-offset/upper address bits carry no information for a word RAM.
  assign w_unused = ^{data_sram_size, data_sram_addr};

  assign w_push            = data_sram_req && !addr_stall && !reset && (r_count < DEPTH_CNT);
  assign data_sram_addr_ok = w_push;

  assign ram_en    = w_push;
  assign ram_we    = (w_push && data_sram_wr) ? data_sram_wstrb : 4'b0000;
  assign ram_addr  = data_sram_addr[ADDR_W+1:2];
  assign ram_wdata = data_sram_wdata;

  // A capturing load counts as data-valid in its capture cycle so loads and stores share latency.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_eff_vld = r_vld;
    if (r_cap_pend) w_eff_vld[r_cap_idx] = 1'b1;
  end

  assign w_head_cap = r_cap_pend && (r_cap_idx == r_rd_ptr);
  assign w_pop      = r_occ[r_rd_ptr] && w_eff_vld[r_rd_ptr] && (r_dly[r_rd_ptr] == 4'd0);

  assign data_sram_data_ok = w_pop;
  assign data_sram_rdata   = (w_pop && !r_is_wr[r_rd_ptr])
                           ? (w_head_cap ? ram_rdata : r_data[r_rd_ptr])
                           : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_occ      <= '0;
      r_is_wr    <= '0;
      r_vld      <= '0;
      r_cap_pend <= 1'b0;
      r_cap_idx  <= '0;
      for (int i = 0; i < DEPTH; i++) r_dly[i] <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; later statements below win on the same slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (r_occ[i] && w_eff_vld[i] && (r_dly[i] != 4'd0)) r_dly[i] <= r_dly[i] - 4'd1;
      end

      if (r_cap_pend) r_vld[r_cap_idx] <= 1'b1;

      if (w_pop) begin
        r_occ[r_rd_ptr] <= 1'b0;
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= f_next(r_rd_ptr);
      end

      if (w_push) begin
        r_occ[r_wr_ptr]   <= 1'b1;
        r_is_wr[r_wr_ptr] <= data_sram_wr;
        r_vld[r_wr_ptr]   <= data_sram_wr;
        r_dly[r_wr_ptr]   <= DLY_INIT;
        r_wr_ptr          <= f_next(r_wr_ptr);
      end

      r_cap_pend <= w_push && !data_sram_wr;
      r_cap_idx  <= r_wr_ptr;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: queue data is storage, not control; it is never read before its slot is written, so it has no reset.
  always_ff @(posedge clk) begin
    if (r_cap_pend) r_data[r_cap_idx] <= ram_rdata;
    if (w_push)     r_data[r_wr_ptr]  <= 32'd0;
  end

endmodule

// File: tb/tb_dsram_like_responder.sv
// Directed bench: three responders (DATA_DELAY 0, 8, 2) each front their own word RAM model,
// preloaded with 0xD000_0000 | word_index.
module tb_dsram_like_responder;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  logic ram_init;

  always #5 clk = ~clk;

  logic        req   [N];
  logic        wr    [N];
  logic        stall [N];
  logic [1:0]  size  [N];
  logic [3:0]  wstrb [N];
  logic [31:0] addr  [N];
  logic [31:0] wdata [N];

  logic        addr_ok   [N];
  logic        data_ok   [N];
  logic [31:0] rdata     [N];
  logic        ram_en    [N];
  logic [3:0]  ram_we    [N];
  logic [15:0] ram_addr  [N];
  logic [31:0] ram_wdata [N];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int DLY = (g == 0) ? 0 : ((g == 1) ? 8 : 2);
    logic [31:0] mem [64];
    logic [31:0] ram_rd;

    dsram_like_responder #(.ADDR_W(16), .DEPTH(4), .DATA_DELAY(DLY)) u_dut (
      .clk               (clk),
      .reset             (reset),
      .data_sram_req     (req[g]),
      .data_sram_wr      (wr[g]),
      .data_sram_size    (size[g]),
      .data_sram_wstrb   (wstrb[g]),
      .data_sram_addr    (addr[g]),
      .data_sram_wdata   (wdata[g]),
      .data_sram_addr_ok (addr_ok[g]),
      .data_sram_data_ok (data_ok[g]),
      .data_sram_rdata   (rdata[g]),
      .addr_stall        (stall[g]),
      .ram_en            (ram_en[g]),
      .ram_we            (ram_we[g]),
      .ram_addr          (ram_addr[g]),
      .ram_wdata         (ram_wdata[g]),
      .ram_rdata         (ram_rd)
    );

    always_ff @(posedge clk) begin
      if (ram_init) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'hD000_0000 | 32'(i);
      end else if (ram_en[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_we[g][b]) mem[ram_addr[g][5:0]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
        end
        if (ram_we[g] == 4'b0000) ram_rd <= mem[ram_addr[g][5:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic drv(input int k, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    req[k]   = r;
    wr[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
    wstrb[k] = s;
    size[k]  = 2'd2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        exp_ok;
    logic        exp_dok;
    logic [31:0] exp_rd;

    reset    = 1'b1;
    ram_init = 1'b1;
    for (int k = 0; k < N; k++) begin
      drv(k, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      stall[k] = 1'b0;
    end
    req[0] = 1'b1;

    // Reset state, with a request pending on instance 0.
    tick();
    ram_init = 1'b0;
    samp();
    check("rst_addr_ok", 32'(addr_ok[0]), 32'd0);
    check("rst_data_ok", 32'(data_ok[0]), 32'd0);
    check("rst_rdata",   rdata[0],        32'd0);
    check("rst_ram_en",  32'(ram_en[0]),  32'd0);
    check("rst_ram_we",  32'(ram_we[0]),  32'd0);
    tick();
    req[0] = 1'b0;
    reset  = 1'b0;

    // Store 0x10 then load 0x10, DATA_DELAY=0.
    tick();
    drv(0, 1'b1, 1'b1, 32'h10, 32'hA5A5_1234, 4'hF);
    samp();
    check("st_addr_ok",   32'(addr_ok[0]), 32'd1);
    check("st_ram_en",    32'(ram_en[0]),  32'd1);
    check("st_ram_we",    32'(ram_we[0]),  32'hF);
    check("st_ram_addr",  32'(ram_addr[0]), 32'h4);
    check("st_ram_wdata", ram_wdata[0],    32'hA5A5_1234);
    check("st_data_ok0",  32'(data_ok[0]), 32'd0);
    tick();
    drv(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
    samp();
    check("st_resp_ok",    32'(data_ok[0]), 32'd1);
    check("st_resp_rdata", rdata[0],        32'd0);
    check("ld_addr_ok",    32'(addr_ok[0]), 32'd1);
    check("ld_ram_we",     32'(ram_we[0]),  32'd0);
    tick();
    drv(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    samp();
    check("ld_resp_ok",    32'(data_ok[0]), 32'd1);
    check("ld_resp_rdata", rdata[0],        32'hA5A5_1234);
    tick();
    samp();
    check("idle_data_ok", 32'(data_ok[0]), 32'd0);
    check("idle_rdata",   rdata[0],        32'd0);
    check("idle_ram_en",  32'(ram_en[0]),  32'd0);

    // Byte strobe merge and address wrap above the RAM word range.
    tick();
    drv(0, 1'b1, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
    samp();
    check("bs_full_ok", 32'(addr_ok[0]), 32'd1);
    tick();
    drv(0, 1'b1, 1'b1, 32'h20, 32'hEEEE_EEEE, 4'b0100);
    samp();
    check("bs_ram_we",  32'(ram_we[0]),  32'h4);
    check("bs_resp1",   32'(data_ok[0]), 32'd1);
    check("bs_rdata1",  rdata[0],        32'd0);
    tick();
    drv(0, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0);
    samp();
    check("bs_resp2",   32'(data_ok[0]), 32'd1);
    check("bs_rdata2",  rdata[0],        32'd0);
    tick();
    drv(0, 1'b1, 1'b0, 32'h0004_0010, 32'd0, 4'd0);
    samp();
    check("bs_ld_ok",    32'(data_ok[0]),  32'd1);
    check("bs_ld_rdata", rdata[0],         32'h11EE_3344);
    check("wrap_ram_addr", 32'(ram_addr[0]), 32'h4);
    tick();
    drv(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    samp();
    check("wrap_ld_ok",    32'(data_ok[0]), 32'd1);
    check("wrap_ld_rdata", rdata[0],        32'hA5A5_1234);
    tick();
    samp();
    check("bs_idle", 32'(data_ok[0]), 32'd0);

    // addr_stall holds off acceptance for 5 cycles.
    for (int c = 0; c < 5; c++) begin
      tick();
      drv(0, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0);
      stall[0] = 1'b1;
      samp();
      check("stall_addr_ok", 32'(addr_ok[0]), 32'd0);
      check("stall_ram_en",  32'(ram_en[0]),  32'd0);
      check("stall_data_ok", 32'(data_ok[0]), 32'd0);
    end
    tick();
    stall[0] = 1'b0;
    samp();
    check("unstall_addr_ok", 32'(addr_ok[0]), 32'd1);
    check("unstall_ram_en",  32'(ram_en[0]),  32'd1);
    tick();
    req[0] = 1'b0;
    samp();
    check("unstall_resp",  32'(data_ok[0]), 32'd1);
    check("unstall_rdata", rdata[0],        32'h11EE_3344);

    // Full queue on instance 1 (DEPTH=4, DATA_DELAY=8): 5th request waits for the first pop.
    for (int c = 0; c < 22; c++) begin
      tick();
      if (c <= 10) drv(1, 1'b1, 1'b0, (c < 4) ? 32'(c * 4) : 32'h10, 32'd0, 4'd0);
      else         req[1] = 1'b0;
      samp();
      exp_ok  = (c <= 3) || (c == 10);
      exp_dok = ((c >= 9) && (c <= 12)) || (c == 19);
      exp_rd  = !exp_dok ? 32'd0 : ((c == 19) ? 32'hD000_0004 : 32'hD000_0000 + 32'(c - 9));
      check("full_addr_ok", 32'(addr_ok[1]), 32'(exp_ok));
      check("full_ram_en",  32'(ram_en[1]),  32'(exp_ok));
      check("full_data_ok", 32'(data_ok[1]), 32'(exp_dok));
      check("full_rdata",   rdata[1],        exp_rd);
    end

    // Streaming on instance 2 (DATA_DELAY=2): 12 back-to-back loads, pointers wrap three times.
    for (int c = 0; c < 17; c++) begin
      tick();
      if (c < 12) drv(2, 1'b1, 1'b0, 32'(c * 4), 32'd0, 4'd0);
      else        req[2] = 1'b0;
      samp();
      exp_dok = (c >= 3) && (c <= 14);
      exp_rd  = exp_dok ? 32'hD000_0000 + 32'(c - 3) : 32'd0;
      check("strm_addr_ok", 32'(addr_ok[2]), 32'(c < 12));
      check("strm_data_ok", 32'(data_ok[2]), 32'(exp_dok));
      check("strm_rdata",   rdata[2],        exp_rd);
    end

    // Reset with three loads pending on instance 1: none of them may be answered.
    for (int c = 0; c < 3; c++) begin
      tick();
      drv(1, 1'b1, 1'b0, 32'(c * 4), 32'd0, 4'd0);
      samp();
      check("rmid_addr_ok", 32'(addr_ok[1]), 32'd1);
    end
    tick();
    req[1] = 1'b0;
    reset  = 1'b1;
    samp();
    check("rmid_in_rst_ok", 32'(data_ok[1]), 32'd0);
    tick();
    samp();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 14; c++) begin
      samp();
      check("rmid_no_resp", 32'(data_ok[1]), 32'd0);
      tick();
    end
    // Four fresh loads must all be accepted, proving the count restarted at zero.
    for (int c = 0; c < 14; c++) begin
      if (c < 4) drv(1, 1'b1, 1'b0, 32'((5 + c) * 4), 32'd0, 4'd0);
      else       req[1] = 1'b0;
      samp();
      exp_dok = (c >= 9) && (c <= 12);
      exp_rd  = exp_dok ? 32'hD000_0005 + 32'(c - 9) : 32'd0;
      check("rpost_addr_ok", 32'(addr_ok[1]), 32'(c < 4));
      check("rpost_data_ok", 32'(data_ok[1]), 32'(exp_dok));
      check("rpost_rdata",   rdata[1],        exp_rd);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
